// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS datapath memory port
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and asynchronous read
module dmem_array #(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wa,
    input  logic [31:0]          wd,
    input  logic [ADDR_BITS-1:0] ra,
    output logic [31:0]          rd
);

    // No reset: contents are undefined until first written.
    logic [31:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory responder for the datapath load/store port
module dmem_responder
    import mips_pkg::*;
#(
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int         OFF_BITS = $clog2(WORD_BYTES);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    mem_state_t  state;
    logic [3:0]  cnt;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic        h_we;
    logic        bad;
    logic        mem_we;
    logic [31:0] mem_rd;

    assign bad = (h_addr[OFF_BITS-1:0] != '0) || (h_addr[31:ADDR_BITS+OFF_BITS] != '0);

    // Commit on the edge entering RESP; a reset on that edge drops the store.
    assign mem_we = reset && (state == WAIT) && (cnt == 4'd0) && h_we && !bad;

    dmem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk (clk),
        .we  (mem_we),
        .wa  (h_addr[ADDR_BITS+OFF_BITS-1:OFF_BITS]),
        .wd  (h_wdata),
        .ra  (h_addr[ADDR_BITS+OFF_BITS-1:OFF_BITS]),
        .rd  (mem_rd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            h_addr  <= 32'd0;
            h_we    <= 1'b0;
            h_wdata <= 32'd0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        h_addr  <= addr;
                        h_we    <= we;
                        h_wdata <= wdata;
                        cnt     <= CNT_INIT;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= bad;
                        rdata <= (bad || h_we) ? 32'd0 : mem_rd;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                    rdata <= 32'd0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                    rdata <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int AB  = 6;
    localparam int LAT = 2;
    localparam int NB  = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, busy, err;
    logic        req1, we1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ready1, busy1, err1;

    int checks = 0;
    int errors = 0;

    logic [31:0] model  [int];
    logic [31:0] model1 [int];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    dmem_responder #(.ADDR_BITS(AB), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 << AB));
    endfunction

    // One transaction on the LATENCY=2 responder; optional junk on the inputs while busy.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit junk, input string tag);
        bit          bad;
        bit          chk_rd;
        logic [31:0] exp_rd;
        bad    = addr_bad(a);
        exp_rd = 32'd0;
        chk_rd = 1'b1;
        if (!bad && !w) begin
            if (model.exists(int'(a >> 2))) exp_rd = model[int'(a >> 2)];
            else chk_rd = 1'b0;
        end
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int i = 1; i <= LAT + 2; i++) begin
            @(negedge clk);
            if (i <= LAT + 1 && junk) begin
                req = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
            end else begin
                req = 1'b0;
            end
            chk({tag, " busy"},  32'(busy),  32'(i <= LAT + 1));
            chk({tag, " ready"}, 32'(ready), 32'(i == LAT + 1));
            if (i == LAT + 1) begin
                chk({tag, " err"}, 32'(err), 32'(bad));
                if (chk_rd) chk({tag, " rdata"}, rdata, exp_rd);
            end
            if (i == LAT + 2) begin
                chk({tag, " err_clr"},   32'(err), 32'd0);
                chk({tag, " rdata_clr"}, rdata,    32'd0);
            end
        end
        req = 1'b0;
        if (!bad && w) model[int'(a >> 2)] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ba [NB];
        logic [31:0] bd [NB];
        logic        bw [NB];
        logic [31:0] exp_rd1 [NB];
        logic        exp_err1 [NB];
        logic        w;
        logic [31:0] a;
        int          sel;
        int          t;

        reset = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst rdata", rdata, 32'd0);
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst busy",  32'(busy),  32'd0);
        chk("rst err",   32'(err),   32'd0);
        chk("rst1 ready", 32'(ready1), 32'd0);
        chk("rst1 busy",  32'(busy1),  32'd0);
        reset = 1'b1;
        @(negedge clk);

        txn(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, "st0");
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "st10");
        txn(1'b0, 32'h0000_0010, 32'd0,         1'b0, "ld10");
        txn(1'b0, 32'h0000_0012, 32'd0,         1'b0, "ld_misalign");
        txn(1'b0, 32'h0000_0010, 32'd0,         1'b0, "ld10_again");
        txn(1'b1, 32'h0000_0100, 32'h5555_AAAA, 1'b0, "st_oor");
        txn(1'b0, 32'h0000_0000, 32'd0,         1'b0, "ld0_after_oor");
        txn(1'b1, 32'h0000_0024, 32'h1234_5678, 1'b1, "st24_junk");
        txn(1'b0, 32'h0000_0024, 32'd0,         1'b1, "ld24_junk");

        // Reset during WAIT drops the in-flight store.
        txn(1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, "st20");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h2222_2222;
        @(negedge clk);
        chk("abort busy_before", 32'(busy), 32'd1);
        reset = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(ready), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no_ready", 32'(ready), 32'd0);
        end
        txn(1'b0, 32'h0000_0020, 32'd0, 1'b0, "ld20_after_abort");

        // Reset and req together: request must not be accepted.
        @(negedge clk);
        reset = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h3333_3333;
        @(negedge clk);
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("rst_req busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst_req ready", 32'(ready), 32'd0);
        txn(1'b0, 32'h0000_0020, 32'd0, 1'b0, "ld20_after_rst_req");

        for (int k = 0; k < 16; k++) begin
            w   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
            else               a = 32'(4 * $urandom_range(0, 15));
            txn(w, a, $urandom, 1'($urandom_range(0, 1)), "rand");
        end

        // Back-to-back on the LATENCY=1 responder with req held high.
        for (int i = 0; i < 4; i++) begin
            ba[i] = 32'(i * 16 + 4 * $urandom_range(0, 3));
            bd[i] = $urandom;
            bw[i] = 1'b1;
            ba[i + 4] = ba[i];
            bd[i + 4] = 32'd0;
            bw[i + 4] = 1'b0;
        end
        ba[8] = 32'h0000_0013; bd[8] = 32'd0; bw[8] = 1'b0;
        for (int i = 0; i < NB; i++) begin
            exp_err1[i] = addr_bad(ba[i]);
            exp_rd1[i]  = 32'd0;
            if (!exp_err1[i] && bw[i]) model1[int'(ba[i] >> 2)] = bd[i];
            if (!exp_err1[i] && !bw[i]) exp_rd1[i] = model1[int'(ba[i] >> 2)];
        end
        for (int n = 0; n < 3 * NB; n++) begin
            @(negedge clk);
            if (n == 0 || n % 3 == 1) begin
                t = (n + 2) / 3;
                if (t < NB) begin
                    req1 = 1'b1; we1 = bw[t]; addr1 = ba[t]; wdata1 = bd[t];
                end else begin
                    req1 = 1'b0;
                end
            end
            if (n > 0) begin
                chk("b2b busy",  32'(busy1),  32'(n % 3 != 0));
                chk("b2b ready", 32'(ready1), 32'(n % 3 == 2));
                if (n % 3 == 2) begin
                    chk("b2b rdata", rdata1,      exp_rd1[(n - 2) / 3]);
                    chk("b2b err",   32'(err1),   32'(exp_err1[(n - 2) / 3]));
                end
            end
        end
        req1 = 1'b0;
        @(negedge clk);
        chk("b2b idle busy",  32'(busy1),  32'd0);
        chk("b2b idle ready", 32'(ready1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
